// File: rtl/note_scheduler.sv
// note_scheduler
//   Chart sequencer for the lane droppers. It walks a note chart held in an
//   external synchronous ROM and emits one-frame spawn pulses to the per-lane
//   droppers at scheduled frame offsets. It also tracks unresolved notes per
//   lane and accumulates score, combo and max combo from hit/miss reports.
//
// Ports
//   frame_clk   in   1               frame clock, sole clock
//   Reset       in   1               synchronous active-high reset
//   keycode     in   8               8'h2C start, 8'h29 abort, 8'h01 back to idle
//   chart_addr  out  ADDR_W          registered ROM address
//   chart_data  in   DELTA_W+LANES   {delta, lane_mask} for last cycle's chart_addr
//   hit         in   LANES           per-lane hit pulse from droppers
//   miss        in   LANES           per-lane miss pulse from droppers
//   spawn       out  LANES           one-cycle spawn pulse per lane (registered)
//   playing     out  1               high in FETCH, LOAD, WAIT, ISSUE, DRAIN
//   finished    out  1               high in DONE
//   score       out  SCORE_W         saturating hit count
//   combo       out  8               saturating consecutive-hit count
//   max_combo   out  8               highest combo this run
module note_scheduler #(
  parameter int LANES   = 4,
  parameter int ADDR_W  = 8,
  parameter int DELTA_W = 12,
  parameter int SCORE_W = 16
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [7:0]               keycode,
  output logic [ADDR_W-1:0]        chart_addr,
  input  logic [DELTA_W+LANES-1:0] chart_data,
  input  logic [LANES-1:0]         hit,
  input  logic [LANES-1:0]         miss,
  output logic [LANES-1:0]         spawn,
  output logic                     playing,
  output logic                     finished,
  output logic [SCORE_W-1:0]       score,
  output logic [7:0]               combo,
  output logic [7:0]               max_combo
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Number of set bits, kept LANES wide; callers zero-extend.
  function automatic logic [LANES-1:0] popcount(input logic [LANES-1:0] v);
    logic [LANES-1:0] c;
    c = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      c = c + {{(LANES-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [2:0]         state_r, state_s;
  logic [DELTA_W-1:0] cnt_r, cnt_s;
  logic [LANES-1:0]   mask_r, mask_s;
  logic [LANES-1:0]   pending_r, pending_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [SCORE_W-1:0] score_s;
  logic [7:0]         combo_s, max_s;

  logic               key_start_s, key_abort_s, key_idle_s;
  logic               playing_state_s, abort_s, issue_s, break_s;
  logic [LANES-1:0]   hm_s, collide_s, spawn_bits_s, hits_s, h_s;
  logic [8:0]         combo_sum_s;
  logic [SCORE_W:0]   score_sum_s;
  logic [DELTA_W-1:0] delta_s;

  assign key_start_s     = (keycode == 8'h2C);
  assign key_abort_s     = (keycode == 8'h29);
  assign key_idle_s      = (keycode == 8'h01);
  assign playing_state_s = (state_r == S_FETCH) || (state_r == S_LOAD) ||
                           (state_r == S_WAIT)  || (state_r == S_ISSUE) ||
                           (state_r == S_DRAIN);
  assign abort_s         = playing_state_s && key_abort_s;
  assign issue_s         = (state_r == S_ISSUE) && !abort_s;
  assign delta_s         = chart_data[DELTA_W+LANES-1:LANES];
  assign hm_s            = hit | miss;

  // A lane still holding an unresolved note (and not resolving it now)
  // cannot take another spawn; a hit or miss this cycle frees it in time.
  assign collide_s    = issue_s ? (mask_r & pending_r & ~hm_s) : {LANES{1'b0}};
  assign spawn_bits_s = issue_s ? (mask_r & ~collide_s) : {LANES{1'b0}};

  // Hit together with miss on one lane counts as a miss only.
  assign hits_s      = hit & pending_r & ~miss;
  assign h_s         = popcount(hits_s);
  assign break_s     = (|(miss & pending_r)) || (|collide_s);
  assign combo_sum_s = {1'b0, combo} + {{(9-LANES){1'b0}}, h_s};
  assign score_sum_s = {1'b0, score} + {{(SCORE_W+1-LANES){1'b0}}, h_s};

  // Sequencer next-state: chart walk, wait counter and ROM address.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mask_s  = mask_r;
    addr_s  = chart_addr;
    if (abort_s) begin
      state_s = S_IDLE;
      cnt_s   = {DELTA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (key_start_s) begin
            state_s = S_FETCH;
            addr_s  = {ADDR_W{1'b0}};
          end else begin
            state_s = S_IDLE;
          end
        end
        S_FETCH: begin
          state_s = S_LOAD;
        end
        S_LOAD: begin
          mask_s = chart_data[LANES-1:0];
          if (delta_s == {DELTA_W{1'b1}}) begin
            state_s = S_DRAIN;
          end else begin
            cnt_s   = delta_s;
            state_s = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_r == {DELTA_W{1'b0}}) begin
            state_s = S_ISSUE;
          end else begin
            cnt_s = cnt_r - {{(DELTA_W-1){1'b0}}, 1'b1};
          end
        end
        S_ISSUE: begin
          // The last ROM slot ends the chart; the address never wraps.
          if (chart_addr == {ADDR_W{1'b1}}) begin
            state_s = S_DRAIN;
          end else begin
            addr_s  = chart_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_s = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (pending_r == {LANES{1'b0}}) begin
            state_s = S_DONE;
          end else begin
            state_s = S_DRAIN;
          end
        end
        S_DONE: begin
          if (key_idle_s) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_DONE;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Pending-note bookkeeping and saturating score/combo accumulation.
  always_comb begin
    pending_s = pending_r;
    score_s   = score;
    combo_s   = combo;
    max_s     = max_combo;
    if ((state_r == S_IDLE) && key_start_s) begin
      pending_s = {LANES{1'b0}};
      score_s   = {SCORE_W{1'b0}};
      combo_s   = 8'd0;
      max_s     = 8'd0;
    end else if (abort_s) begin
      pending_s = {LANES{1'b0}};
    end else begin
      // Resolve first, then set newly spawned lanes.
      pending_s = (pending_r & ~hm_s) | spawn_bits_s;
      if (break_s) begin
        combo_s = 8'd0;
      end else begin
        combo_s = combo_sum_s[8] ? 8'hFF : combo_sum_s[7:0];
        score_s = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
      end
      max_s = (combo_s > max_combo) ? combo_s : max_combo;
    end
  end

  // State and output registers; reset overrides every other event.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= {DELTA_W{1'b0}};
      mask_r     <= {LANES{1'b0}};
      pending_r  <= {LANES{1'b0}};
      chart_addr <= {ADDR_W{1'b0}};
      spawn      <= {LANES{1'b0}};
      playing    <= 1'b0;
      finished   <= 1'b0;
      score      <= {SCORE_W{1'b0}};
      combo      <= 8'd0;
      max_combo  <= 8'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      mask_r     <= mask_s;
      pending_r  <= pending_s;
      chart_addr <= addr_s;
      spawn      <= spawn_bits_s;
      playing    <= (state_s == S_FETCH) || (state_s == S_LOAD) ||
                    (state_s == S_WAIT)  || (state_s == S_ISSUE) ||
                    (state_s == S_DRAIN);
      finished   <= (state_s == S_DONE);
      score      <= score_s;
      combo      <= combo_s;
      max_combo  <= max_s;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler
//   Directed scoreboard bench for note_scheduler. Stimulus code pushes expected
//   output values tagged with the cycle they must appear; a monitor on the
//   falling edge pops and compares them, and flags spawn pulses nobody expected.
//   A second instance with a 10-bit score makes score saturation reachable.
module tb_note_scheduler;

  localparam int LANES   = 4;
  localparam int ADDR_W  = 8;
  localparam int DELTA_W = 12;
  localparam int SCORE_W = 16;
  localparam int SAT_W   = 10;

  logic                     frame_clk = 1'b0;
  logic                     Reset;
  logic [7:0]               keycode;
  logic [ADDR_W-1:0]        chart_addr, s_chart_addr;
  logic [DELTA_W+LANES-1:0] chart_data;
  logic [LANES-1:0]         hit, miss, spawn, s_spawn;
  logic                     playing, finished, s_playing, s_finished;
  logic [SCORE_W-1:0]       score;
  logic [SAT_W-1:0]         s_score;
  logic [7:0]               combo, max_combo, s_combo, s_max_combo;

  logic [DELTA_W+LANES-1:0] rom [0:255];

  note_scheduler #(.LANES(LANES), .ADDR_W(ADDR_W), .DELTA_W(DELTA_W), .SCORE_W(SCORE_W)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .chart_addr(chart_addr),
    .chart_data(chart_data), .hit(hit), .miss(miss), .spawn(spawn), .playing(playing),
    .finished(finished), .score(score), .combo(combo), .max_combo(max_combo));

  note_scheduler #(.LANES(LANES), .ADDR_W(ADDR_W), .DELTA_W(DELTA_W), .SCORE_W(SAT_W)) dut_sat (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .chart_addr(s_chart_addr),
    .chart_data(chart_data), .hit(hit), .miss(miss), .spawn(s_spawn), .playing(s_playing),
    .finished(s_finished), .score(s_score), .combo(s_combo), .max_combo(s_max_combo));

  always #5 frame_clk = ~frame_clk;

  // Synchronous chart ROM: data follows the previous cycle's address.
  always @(posedge frame_clk) chart_data <= rom[chart_addr];

  int cyc = 0;
  always @(posedge frame_clk) cyc <= cyc + 1;

  localparam int K_SPAWN = 0, K_PLAY = 1, K_FIN = 2, K_SCORE = 3, K_COMBO = 4, K_MAX = 5,
                 K_ADDR = 6, K_SSCORE = 7, K_SCOMBO = 8, K_SMAX = 9, K_SADDR = 10,
                 K_SFIN = 11, K_SPLAY = 12;

  typedef struct {
    int          at;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic expect_at(input int at, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.at = at; e.kind = kind; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] act_of(input int kind);
    case (kind)
      K_SPAWN:  return 32'(spawn);
      K_PLAY:   return 32'(playing);
      K_FIN:    return 32'(finished);
      K_SCORE:  return 32'(score);
      K_COMBO:  return 32'(combo);
      K_MAX:    return 32'(max_combo);
      K_ADDR:   return 32'(chart_addr);
      K_SSCORE: return 32'(s_score);
      K_SCOMBO: return 32'(s_combo);
      K_SMAX:   return 32'(s_max_combo);
      K_SADDR:  return 32'(s_chart_addr);
      K_SFIN:   return 32'(s_finished);
      K_SPLAY:  return 32'(s_playing);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, flag stray spawns.
  always @(negedge frame_clk) begin
    logic [31:0] act;
    bit          spawn_checked;
    spawn_checked = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        act = act_of(sb[i].kind);
        n_total++;
        if (act == sb[i].val) n_pass++;
        else $display("FAIL %s at cycle %0d: actual %0h, expected %0h", sb[i].name, cyc, act, sb[i].val);
        if (sb[i].kind == K_SPAWN) spawn_checked = 1'b1;
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_total++;
        $display("FAIL %s: check for cycle %0d was skipped (now %0d)", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
    if (((spawn | s_spawn) != 4'b0000) && !spawn_checked) begin
      n_total++;
      $display("FAIL unexpected_spawn at cycle %0d: actual %0h/%0h, expected 0", cyc, spawn, s_spawn);
    end
  end

  task automatic to_cycle(input int t);
    while (cyc < t) @(negedge frame_clk);
  endtask

  initial begin
    int c;
    Reset = 1'b1; keycode = 8'h00; hit = 4'b0000; miss = 4'b0000;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    @(negedge frame_clk);

    // Reset state
    c = cyc;
    expect_at(c + 1, K_SPAWN, 32'd0, "rst_spawn");
    expect_at(c + 1, K_PLAY,  32'd0, "rst_playing");
    expect_at(c + 1, K_FIN,   32'd0, "rst_finished");
    expect_at(c + 1, K_SCORE, 32'd0, "rst_score");
    expect_at(c + 1, K_COMBO, 32'd0, "rst_combo");
    expect_at(c + 1, K_MAX,   32'd0, "rst_max");
    expect_at(c + 1, K_ADDR,  32'd0, "rst_addr");
    to_cycle(c + 1);
    Reset = 1'b0;
    to_cycle(c + 3);

    // Tests 1+2: basic chart, then hits, DONE, back to IDLE
    rom[0] = {12'd3, 4'b0001}; rom[1] = {12'd0, 4'b0010}; rom[2] = {12'hFFF, 4'b0000};
    c = cyc;
    expect_at(c + 1,  K_PLAY,  32'd1, "t1_playing");
    expect_at(c + 1,  K_ADDR,  32'd0, "t1_addr0");
    expect_at(c + 8,  K_SPAWN, 32'h1, "t1_spawn0");
    expect_at(c + 12, K_SPAWN, 32'h2, "t1_spawn1");
    expect_at(c + 15, K_FIN,   32'd0, "t1_drain_fin");
    expect_at(c + 16, K_SCORE, 32'd1, "t2_score1");
    expect_at(c + 17, K_SCORE, 32'd2, "t2_score2");
    expect_at(c + 17, K_COMBO, 32'd2, "t2_combo2");
    expect_at(c + 17, K_FIN,   32'd0, "t2_not_done_yet");
    expect_at(c + 18, K_FIN,   32'd1, "t2_done");
    expect_at(c + 18, K_PLAY,  32'd0, "t2_not_playing");
    expect_at(c + 18, K_MAX,   32'd2, "t2_max2");
    expect_at(c + 18, K_ADDR,  32'd2, "t2_addr2");
    expect_at(c + 21, K_FIN,   32'd0, "t2_idle_fin");
    expect_at(c + 21, K_SCORE, 32'd2, "t2_score_kept");
    keycode = 8'h2C; to_cycle(c + 1); keycode = 8'h00;
    to_cycle(c + 15); hit = 4'b0001;
    to_cycle(c + 16); hit = 4'b0010;
    to_cycle(c + 17); hit = 4'b0000;
    to_cycle(c + 20); keycode = 8'h01;
    to_cycle(c + 21); keycode = 8'h00;
    to_cycle(c + 23);

    // Test 3: miss clears combo, hit on non-pending lane ignored
    rom[0] = {12'd0, 4'b0011}; rom[1] = {12'hFFF, 4'b0000};
    c = cyc;
    expect_at(c + 1, K_SCORE, 32'd0, "t3_start_clr_score");
    expect_at(c + 1, K_MAX,   32'd0, "t3_start_clr_max");
    expect_at(c + 5, K_SPAWN, 32'h3, "t3_spawn");
    expect_at(c + 7, K_COMBO, 32'd1, "t3_combo1");
    expect_at(c + 8, K_COMBO, 32'd0, "t3_miss_combo");
    expect_at(c + 8, K_MAX,   32'd1, "t3_miss_max_kept");
    expect_at(c + 9, K_SCORE, 32'd1, "t3_stray_hit_score");
    expect_at(c + 9, K_COMBO, 32'd0, "t3_stray_hit_combo");
    expect_at(c + 9, K_FIN,   32'd1, "t3_done");
    keycode = 8'h2C; to_cycle(c + 1); keycode = 8'h00;
    to_cycle(c + 6); hit = 4'b0010;
    to_cycle(c + 7); hit = 4'b0000; miss = 4'b0001;
    to_cycle(c + 8); miss = 4'b0000; hit = 4'b0100;
    to_cycle(c + 9); hit = 4'b0000;
    to_cycle(c + 11); keycode = 8'h01;
    to_cycle(c + 12); keycode = 8'h00;
    to_cycle(c + 14);

    // Test 4: collision suppresses spawn; hit in ISSUE cycle is not a collision
    rom[0] = {12'd0, 4'b0011}; rom[1] = {12'd0, 4'b0001};
    rom[2] = {12'd0, 4'b0001}; rom[3] = {12'hFFF, 4'b0000};
    c = cyc;
    expect_at(c + 5,  K_SPAWN, 32'h3, "t4_spawn0");
    expect_at(c + 6,  K_COMBO, 32'd1, "t4_combo1");
    expect_at(c + 9,  K_SPAWN, 32'h0, "t4_collide_spawn");
    expect_at(c + 9,  K_COMBO, 32'd0, "t4_collide_combo");
    expect_at(c + 9,  K_SCORE, 32'd1, "t4_collide_score");
    expect_at(c + 13, K_SPAWN, 32'h1, "t4_hit_issue_spawn");
    expect_at(c + 13, K_SCORE, 32'd2, "t4_hit_issue_score");
    expect_at(c + 16, K_SCORE, 32'd3, "t4_final_score");
    expect_at(c + 16, K_MAX,   32'd2, "t4_final_max");
    expect_at(c + 17, K_FIN,   32'd1, "t4_done");
    keycode = 8'h2C; to_cycle(c + 1); keycode = 8'h00;
    to_cycle(c + 5);  hit = 4'b0010;
    to_cycle(c + 6);  hit = 4'b0000;
    to_cycle(c + 12); hit = 4'b0001;
    to_cycle(c + 13); hit = 4'b0000;
    to_cycle(c + 15); hit = 4'b0001;
    to_cycle(c + 16); hit = 4'b0000;
    to_cycle(c + 19); keycode = 8'h01;
    to_cycle(c + 20); keycode = 8'h00;
    to_cycle(c + 22);

    // Test 5a: reset in WAIT with counter 7
    rom[0] = {12'd0, 4'b0001}; rom[1] = {12'd10, 4'b0001}; rom[2] = {12'hFFF, 4'b0000};
    c = cyc;
    expect_at(c + 5,  K_SPAWN, 32'h1, "t5_spawn0");
    expect_at(c + 10, K_SCORE, 32'd1, "t5_score_before_rst");
    expect_at(c + 10, K_PLAY,  32'd1, "t5_playing_before_rst");
    expect_at(c + 11, K_PLAY,  32'd0, "t5_rst_playing");
    expect_at(c + 11, K_SPAWN, 32'h0, "t5_rst_spawn");
    expect_at(c + 11, K_SCORE, 32'd0, "t5_rst_score");
    expect_at(c + 11, K_COMBO, 32'd0, "t5_rst_combo");
    expect_at(c + 11, K_MAX,   32'd0, "t5_rst_max");
    expect_at(c + 11, K_ADDR,  32'd0, "t5_rst_addr");
    expect_at(c + 25, K_PLAY,  32'd0, "t5_stays_idle");
    keycode = 8'h2C; to_cycle(c + 1); keycode = 8'h00;
    to_cycle(c + 5);  hit = 4'b0001;
    to_cycle(c + 6);  hit = 4'b0000;
    to_cycle(c + 10); Reset = 1'b1;
    to_cycle(c + 11); Reset = 1'b0;
    to_cycle(c + 30);

    // Test 5b: abort in WAIT keeps score
    c = cyc;
    expect_at(c + 5,  K_SPAWN, 32'h1, "t5b_spawn0");
    expect_at(c + 11, K_PLAY,  32'd0, "t5b_abort_playing");
    expect_at(c + 11, K_FIN,   32'd0, "t5b_abort_finished");
    expect_at(c + 11, K_SCORE, 32'd1, "t5b_abort_score");
    expect_at(c + 11, K_COMBO, 32'd1, "t5b_abort_combo");
    expect_at(c + 11, K_MAX,   32'd1, "t5b_abort_max");
    expect_at(c + 25, K_PLAY,  32'd0, "t5b_stays_idle");
    keycode = 8'h2C; to_cycle(c + 1); keycode = 8'h00;
    to_cycle(c + 5);  hit = 4'b0001;
    to_cycle(c + 6);  hit = 4'b0000;
    to_cycle(c + 10); keycode = 8'h29;
    to_cycle(c + 11); keycode = 8'h00;
    to_cycle(c + 30);

    // Test 6: full 256-entry chart, no end marker, forced hits on all lanes
    for (int i = 0; i < 256; i++) rom[i] = {12'd0, 4'b1111};
    c = cyc;
    for (int k = 0; k < 256; k++) expect_at(c + 5 + 4 * k, K_SPAWN, 32'hF, "t6_spawn");
    expect_at(c + 1025, K_ADDR,   32'd255,  "t6_addr_no_wrap");
    expect_at(c + 1025, K_PLAY,   32'd1,    "t6_drain_playing");
    expect_at(c + 1026, K_FIN,    32'd0,    "t6_drain_fin");
    expect_at(c + 1027, K_FIN,    32'd1,    "t6_done");
    expect_at(c + 1027, K_ADDR,   32'd255,  "t6_addr_final");
    expect_at(c + 1027, K_SCORE,  32'd1024, "t6_score");
    expect_at(c + 1027, K_COMBO,  32'd255,  "t6_combo_sat");
    expect_at(c + 1027, K_MAX,    32'd255,  "t6_max_sat");
    expect_at(c + 1027, K_SSCORE, 32'h3FF,  "t6_score_sat");
    expect_at(c + 1027, K_SCOMBO, 32'd255,  "t6_sat_combo");
    expect_at(c + 1027, K_SMAX,   32'd255,  "t6_sat_max");
    expect_at(c + 1027, K_SADDR,  32'd255,  "t6_sat_addr");
    expect_at(c + 1027, K_SFIN,   32'd1,    "t6_sat_done");
    expect_at(c + 1027, K_SPLAY,  32'd0,    "t6_sat_playing");
    keycode = 8'h2C; hit = 4'b1111;
    to_cycle(c + 1); keycode = 8'h00;
    to_cycle(c + 1028); hit = 4'b0000;
    to_cycle(c + 1032);

    #1;
    if (sb.size() != 0) begin
      n_total += sb.size();
      $display("FAIL leftover_checks: actual %0d unchecked, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
